dcache_axi_bridge: RTL

Converts the data cache's single-outstanding memory request interface into AXI4-Lite master transactions. It sits directly downstream of the data cache, between the cache and the system interconnect. Line-fill reads and write-through writes each become one 32-bit AXI4-Lite transfer. It returns a one-cycle completion pulse to the cache.

---
 rtl/brv32p_pkg.sv | 35 +++
 rtl/dcache_axi_bridge_sat_counter32.sv | 43 ++++
 rtl/dcache_axi_bridge.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/brv32p_pkg.sv
// -----------------------------------------------------------------------------
// brv32p_pkg
// Shared types for the data-cache AXI4-Lite bridge:
//   axi_resp_e          - AXI response codes
//   dcache_axi_state_e  - bridge FSM states
//   SAT32_MAX           - saturation value for the 32-bit perf counters
//   axi_resp_is_err()   - any response other than OKAY counts as a bus error
// -----------------------------------------------------------------------------
package brv32p_pkg;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_DONE    = 3'd5
  } dcache_axi_state_e;

  localparam logic [31:0] SAT32_MAX = 32'hFFFF_FFFF;

  // The cache has no use for exclusive access, so EXOKAY is reported as an
  // error just like SLVERR/DECERR.
  function automatic logic axi_resp_is_err(input logic [1:0] resp);
    return (resp != AXI_OKAY);
  endfunction

endpackage : brv32p_pkg

// File: rtl/dcache_axi_bridge_sat_counter32.sv
// -----------------------------------------------------------------------------
// sat_counter32
// 32-bit event counter that sticks at 32'hFFFF_FFFF instead of wrapping.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset, clears the count to 0
//   inc_i  - count one event this cycle
//   cnt_o  - current (registered) count
// -----------------------------------------------------------------------------
module sat_counter32
  import brv32p_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Next count: increment only while below the saturation value.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != SAT32_MAX)) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter32

// File: rtl/dcache_axi_bridge.sv
// -----------------------------------------------------------------------------
// dcache_axi_bridge
// Turns the data cache's single-outstanding request interface (level-held
// mem_rd / mem_wr) into one 32-bit AXI4-Lite transfer per request, and returns
// a one-cycle completion pulse (mem_valid for reads, mem_wr_done for writes,
// with bus_err alongside if the slave response was not OKAY).
//
// Parameters:
//   ADDR_W    - address width on both sides
//   AXI_PROT  - constant driven on awprot / arprot
//
// Ports:
//   clk, rst                      - clock; synchronous active-high reset
//   mem_addr/rd/wr/wdata/wstrb    - cache request (levels held until completion)
//   mem_rdata, mem_valid          - read data + read-completion pulse
//   mem_wr_done, bus_err          - write-completion pulse, error pulse
//   m_axi_aw* / w* / b*           - AXI4-Lite write channels
//   m_axi_ar* / r*                - AXI4-Lite read channels
//
// Optional build macro DCACHE_AXI_PERF_EN adds perf_rd_cnt, perf_wr_cnt and
// perf_stall_cnt (saturating 32-bit counters).
// -----------------------------------------------------------------------------
module dcache_axi_bridge
  import brv32p_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [2:0]  AXI_PROT = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  // cache side
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  output logic              mem_valid,
  output logic              mem_wr_done,
  output logic              bus_err,
  // AXI write address
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  // AXI write data
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  // AXI write response
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  // AXI read address
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  // AXI read data
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
`ifdef DCACHE_AXI_PERF_EN
  ,
  output logic [31:0]       perf_rd_cnt,
  output logic [31:0]       perf_wr_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  dcache_axi_state_e state_q;

  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              is_wr_q;
  logic              aw_done_q;
  logic              w_done_q;
  logic [31:0]       rdata_q;

  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              mem_valid_q;
  logic              mem_wr_done_q;
  logic              bus_err_q;

  logic              aw_hs;
  logic              w_hs;
  logic              aw_fin;
  logic              w_fin;

  assign aw_hs  = awvalid_q & m_axi_awready;
  assign w_hs   = wvalid_q  & m_axi_wready;
  // A channel counts as finished if it completed earlier or completes now,
  // so AW and W may finish in either order or in the same cycle.
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q  | w_hs;

  // Bridge FSM with all AXI valids/readies and completion pulses registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= {ADDR_W{1'b0}};
      wdata_q       <= 32'd0;
      wstrb_q       <= 4'd0;
      is_wr_q       <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      rdata_q       <= 32'd0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_wr_done_q <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Writes win over reads when both levels are up.
          if (mem_wr) begin
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
            wstrb_q   <= mem_wstrb;
            is_wr_q   <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= S_WR_REQ;
          end else if (mem_rd) begin
            addr_q    <= mem_addr;
            is_wr_q   <= 1'b0;
            arvalid_q <= 1'b1;
            state_q   <= S_RD_REQ;
          end else begin
            state_q   <= S_IDLE;
          end
        end

        S_WR_REQ: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            bready_q      <= 1'b0;
            bus_err_q     <= axi_resp_is_err(m_axi_bresp);
            mem_wr_done_q <= is_wr_q;
            mem_valid_q   <= ~is_wr_q;
            state_q       <= S_DONE;
          end
        end

        S_RD_REQ: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_RESP;
          end
        end

        S_RD_RESP: begin
          // Data is captured even on an error response.
          if (m_axi_rvalid) begin
            rready_q      <= 1'b0;
            rdata_q       <= m_axi_rdata;
            bus_err_q     <= axi_resp_is_err(m_axi_rresp);
            mem_valid_q   <= ~is_wr_q;
            mem_wr_done_q <= is_wr_q;
            state_q       <= S_DONE;
          end
        end

        S_DONE: begin
          // Request levels are ignored here: the cache only drops or changes
          // its request after seeing this cycle's pulse.
          mem_valid_q   <= 1'b0;
          mem_wr_done_q <= 1'b0;
          bus_err_q     <= 1'b0;
          state_q       <= S_IDLE;
        end

        default: begin
          awvalid_q     <= 1'b0;
          wvalid_q      <= 1'b0;
          bready_q      <= 1'b0;
          arvalid_q     <= 1'b0;
          rready_q      <= 1'b0;
          mem_valid_q   <= 1'b0;
          mem_wr_done_q <= 1'b0;
          bus_err_q     <= 1'b0;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rdata     = rdata_q;
  assign mem_valid     = mem_valid_q;
  assign mem_wr_done   = mem_wr_done_q;
  assign bus_err       = bus_err_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = AXI_PROT;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = AXI_PROT;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

`ifdef DCACHE_AXI_PERF_EN
  logic rd_done_inc;
  logic wr_done_inc;
  logic stall_inc;

  assign rd_done_inc = (state_q == S_DONE) & ~is_wr_q;
  assign wr_done_inc = (state_q == S_DONE) &  is_wr_q;
  assign stall_inc   = (state_q != S_IDLE);

  sat_counter32 u_perf_rd (
    .clk   (clk),
    .rst   (rst),
    .inc_i (rd_done_inc),
    .cnt_o (perf_rd_cnt)
  );

  sat_counter32 u_perf_wr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (wr_done_inc),
    .cnt_o (perf_wr_cnt)
  );

  sat_counter32 u_perf_stall (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall_inc),
    .cnt_o (perf_stall_cnt)
  );
`endif

endmodule : dcache_axi_bridge
